// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the ROM dump engine: FSM encoding, word/byte
// geometry and the word-count clamp.
package rom_reader_pkg;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        RR_IDLE,
        RR_LOAD,
        RR_SEND,
        RR_CSUM,
        RR_DONE
    } rr_state_e;

    function automatic logic [31:0] clamp_count(input logic [31:0] count,
                                                input logic [31:0] limit);
        return (count > limit) ? limit : count;
    endfunction

endpackage

// File: rtl/rom_reader_serializer.sv
// Holds one ROM word and presents it a byte at a time, MSB first; the byte
// advances only when the consumer accepts it.
module rom_reader_serializer
    import rom_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              shift,
    output logic [BYTE_W-1:0] tx_byte,
    output logic              last
);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (load) begin
            shreg_d = word;
            idx_d   = '0;
        end else if (shift) begin
            shreg_d = {shreg_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            idx_d   = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    assign tx_byte = shreg_q[WORD_W-1 -: BYTE_W];
    assign last    = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/rom_reader.sv
// Instruction-memory dump engine: walks sm_rom from word 0 and streams each word
// to the UART TX as bytes, MSB first, optionally followed by an XOR checksum byte.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int SIZE     = 1024,
    parameter bit CHECKSUM = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        start,
    input  logic [31:0] count,
    output logic [31:0] ar,
    input  logic [31:0] rd,
    output logic [7:0]  tx_d,
    output logic        tx_v,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    rr_state_e         state_q, state_d;
    logic [31:0]       ar_q, ar_d;
    logic [31:0]       rem_q, rem_d;
    logic [BYTE_W-1:0] csum_q, csum_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              ser_load, ser_shift, ser_last;
    logic [BYTE_W-1:0] ser_byte;
    logic [31:0]       clamped;
    logic              accept;

    assign clamped = clamp_count(count, 32'(SIZE));
    assign accept  = tx_v & tx_ready;

    rom_reader_serializer u_ser (
        .clk     (clk),
        .rstn    (rstn),
        .load    (ser_load),
        .word    (rd),
        .shift   (ser_shift),
        .tx_byte (ser_byte),
        .last    (ser_last)
    );

    always_comb begin
        state_d   = state_q;
        ar_d      = ar_q;
        rem_d     = rem_q;
        csum_d    = csum_q;
        busy_d    = busy_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        done_d    = (state_q == RR_DONE);

        // Dropping enable abandons the dump silently: no done, in-flight byte ignored.
        if (!enable && (state_q == RR_LOAD || state_q == RR_SEND || state_q == RR_CSUM)) begin
            state_d = RR_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                RR_IDLE: begin
                    if (start && enable) begin
                        ar_d    = '0;
                        rem_d   = clamped;
                        csum_d  = '0;
                        busy_d  = 1'b1;
                        state_d = (clamped == 32'd0) ? RR_DONE : RR_LOAD;
                    end
                end
                RR_LOAD: begin
                    ser_load = 1'b1;
                    state_d  = RR_SEND;
                end
                RR_SEND: begin
                    if (accept) begin
                        ser_shift = 1'b1;
                        csum_d    = csum_q ^ ser_byte;
                        if (ser_last) begin
                            ar_d  = ar_q + 32'd1;
                            rem_d = rem_q - 32'd1;
                            if (rem_q == 32'd1)
                                state_d = CHECKSUM ? RR_CSUM : RR_DONE;
                            else
                                state_d = RR_LOAD;
                        end
                    end
                end
                RR_CSUM: begin
                    if (accept)
                        state_d = RR_DONE;
                end
                RR_DONE: begin
                    busy_d  = 1'b0;
                    state_d = RR_IDLE;
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = RR_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RR_IDLE;
            ar_q    <= '0;
            rem_q   <= '0;
            csum_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            rem_q   <= rem_d;
            csum_q  <= csum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        tx_v = 1'b0;
        tx_d = '0;
        case (state_q)
            RR_SEND: begin
                tx_v = 1'b1;
                tx_d = ser_byte;
            end
            RR_CSUM: begin
                tx_v = 1'b1;
                tx_d = csum_q;
            end
            default: ;
        endcase
    end

    assign ar   = ar_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader: dump content, backpressure, empty and clamped
// dumps, enable abort and mid-dump reset, against a behavioural ROM.
module tb_rom_reader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] count = '0;
    logic [31:0] ar, rd;
    logic [7:0]  tx_d;
    logic        tx_v, busy, done;

    logic [31:0] rom [0:1023];
    assign rd = (ar < 32'd1024) ? rom[ar[9:0]] : 32'h0;

    rom_reader #(.SIZE(1024), .CHECKSUM(1'b1)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (enable),
        .start    (start),
        .count    (count),
        .ar       (ar),
        .rd       (rd),
        .tx_d     (tx_d),
        .tx_v     (tx_v),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, cyc = 0, rdy_mode = 0;
    int txv_cnt = 0, done_cnt = 0, stab_err = 0;
    logic [7:0] bytes [$];
    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = '0;

    // Acceptance is decided by the values standing just before the rising edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (tx_v && tx_ready) bytes.push_back(tx_d);
            if (tx_v) txv_cnt++;
            if (done) done_cnt++;
            if (pv && !pr && tx_v && (tx_d !== pd)) stab_err++;
            pv = tx_v; pr = tx_ready; pd = tx_d;
        end else begin
            pv = 1'b0; pr = 1'b0; pd = '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rdy_mode == 1) tx_ready = (cyc % 3 == 0);
    endtask

    task automatic start_dump(input logic [31:0] n);
        enable = 1'b1;
        start  = 1'b1;
        count  = n;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            tick();
            if (done === 1'b1) break;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    // exp holds n bytes, first byte in the most significant position.
    task automatic check_bytes(input string tag, input int base, input logic [71:0] exp, input int n);
        chk({tag, "_len"}, 32'(bytes.size() - base), 32'(n));
        for (int k = 0; k < n; k++)
            if (base + k < bytes.size())
                chk($sformatf("%s[%0d]", tag, k), 32'(bytes[base+k]), 32'(exp[8*(n-1-k) +: 8]));
    endtask

    initial begin
        int base, d0, v0, mm;
        logic [7:0] model_csum;

        for (int i = 0; i < 1024; i++) rom[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A3C_0F00;
        rom[0] = 32'hDEADBEEF;
        rom[1] = 32'h01020304;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ar",   ar,         32'd0);
        chk("rst_tx_d", 32'(tx_d),  32'd0);
        chk("rst_tx_v", 32'(tx_v),  32'd0);
        chk("rst_busy", 32'(busy),  32'd0);
        chk("rst_done", 32'(done),  32'd0);
        rstn = 1'b1;
        tx_ready = 1'b1;
        tick(); tick();

        // Two words, ready held high; checksum DE^AD^BE^EF^01^02^03^04 = 26.
        base = bytes.size(); d0 = done_cnt;
        start_dump(32'd2);
        chk("t1_busy_load", 32'(busy), 32'd1);
        chk("t1_txv_load",  32'(tx_v), 32'd0);
        chk("t1_ar_load",   ar,        32'd0);
        tick();
        chk("t1_txv_first", 32'(tx_v), 32'd1);
        chk("t1_txd_first", 32'(tx_d), 32'hDE);
        wait_done("t1_done", 100);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_ar_end",   ar,        32'd2);
        tick();
        chk("t1_done_1cyc", 32'(done), 32'd0);
        check_bytes("t1_bytes", base, 72'hDEADBEEF0102030426, 9);
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Same dump under 1-in-3 backpressure.
        base = bytes.size(); d0 = done_cnt;
        rdy_mode = 1;
        start_dump(32'd2);
        wait_done("t2_done", 300);
        tick();
        rdy_mode = 0;
        tx_ready = 1'b1;
        check_bytes("t2_bytes", base, 72'hDEADBEEF0102030426, 9);
        chk("t2_stable",   32'(stab_err),        32'd0);
        chk("t2_done_cnt", 32'(done_cnt - d0),   32'd1);
        chk("t2_ar_end",   ar,                   32'd2);

        // Empty dump.
        base = bytes.size(); d0 = done_cnt; v0 = txv_cnt;
        start_dump(32'd0);
        chk("t3_busy_n1", 32'(busy), 32'd1);
        chk("t3_done_n1", 32'(done), 32'd0);
        tick();
        chk("t3_done_n2", 32'(done), 32'd1);
        chk("t3_busy_n2", 32'(busy), 32'd0);
        tick();
        chk("t3_done_n3", 32'(done), 32'd0);
        chk("t3_no_txv",   32'(txv_cnt - v0),       32'd0);
        chk("t3_no_bytes", 32'(bytes.size() - base), 32'd0);

        // Oversized count clamps to the full ROM; a start mid-dump is ignored.
        model_csum = '0;
        for (int i = 0; i < 1024; i++)
            model_csum = model_csum ^ rom[i][31:24] ^ rom[i][23:16] ^ rom[i][15:8] ^ rom[i][7:0];
        base = bytes.size();
        start_dump(32'd5000);
        repeat (10) tick();
        start = 1'b1; count = 32'd1;
        tick();
        start = 1'b0;
        wait_done("t4_done", 6000);
        chk("t4_ar_end", ar, 32'd1024);
        chk("t4_nbytes", 32'(bytes.size() - base), 32'd4097);
        mm = 0;
        for (int i = 0; i < 4096; i++)
            if (base + i < bytes.size())
                if (bytes[base+i] !== rom[i/4][8*(3 - i%4) +: 8]) mm++;
        chk("t4_data", 32'(mm), 32'd0);
        if (base + 4096 < bytes.size())
            chk("t4_csum", 32'(bytes[base+4096]), 32'(model_csum));

        // Enable dropped after the 6th accepted byte.
        tick();
        base = bytes.size(); d0 = done_cnt;
        start_dump(32'd2);
        for (int k = 0; k < 50; k++) begin
            tick();
            if (bytes.size() - base >= 6) break;
        end
        enable = 1'b0;
        tx_ready = 1'b0;
        chk("t5_six_bytes", 32'(bytes.size() - base), 32'd6);
        tick();
        chk("t5_txv_off", 32'(tx_v), 32'd0);
        chk("t5_busy_off", 32'(busy), 32'd0);
        repeat (4) tick();
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        start = 1'b1; count = 32'd1;
        tick();
        start = 1'b0;
        chk("t5_start_disabled", 32'(busy), 32'd0);
        tick();
        chk("t5_txv_disabled", 32'(tx_v), 32'd0);
        tx_ready = 1'b1;
        base = bytes.size();
        start_dump(32'd1);
        tick();
        chk("t5_restart_txd", 32'(tx_d), 32'hDE);
        wait_done("t5_done", 50);
        chk("t5_ar_end", ar, 32'd1);
        check_bytes("t5_bytes", base, 72'hDEADBEEF22, 5);

        // Asynchronous reset in the middle of SEND.
        tick();
        base = bytes.size();
        start_dump(32'd2);
        for (int k = 0; k < 50; k++) begin
            tick();
            if (bytes.size() - base >= 2) break;
        end
        rstn = 1'b0;
        #1;
        chk("t6_rst_ar",   ar,        32'd0);
        chk("t6_rst_txv",  32'(tx_v), 32'd0);
        chk("t6_rst_txd",  32'(tx_d), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        #1;
        rstn = 1'b1;
        tick();
        base = bytes.size();
        start_dump(32'd1);
        chk("t6_ar_load", ar, 32'd0);
        tick();
        chk("t6_txv_first", 32'(tx_v), 32'd1);
        chk("t6_txd_first", 32'(tx_d), 32'hDE);
        wait_done("t6_done", 50);
        check_bytes("t6_bytes", base, 72'hDEADBEEF22, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
